// File: rtl/pic_pkg.sv
// Shared picture-path definitions: sequencer state encoding, default picture
// geometry and the baud divider helper.
package pic_pkg;

  localparam int unsigned PIC_SIZE_DEF = 9604;  // 98x98 RGB332
  localparam int unsigned ADDR_W_DEF   = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP
  } pic_state_t;

  // Clock cycles per UART bit (integer division, remainder dropped).
  function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serialiser, LSB first. A byte is accepted on load_i while
// ready_o is high. tx_o is a register that follows the internal bit state one
// cycle later, so the line waveform trails state transitions by one clock.
// byte_done_o is high during the final cycle of the stop-bit state.
module uart_byte_tx
  import pic_pkg::*;
#(
  parameter int unsigned BAUD_CNT_MAX = 5208
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       byte_done_o,
  output logic       tx_o
);

  localparam int unsigned CNT_W = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);

  pic_state_t       state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end = (baud_q == CNT_LAST);
  assign ready_o = (state_q == ST_IDLE);
  assign tx_o    = tx_q;

  // Next-state logic: walk START, 8 DATA bits, STOP, each BAUD_CNT_MAX cycles.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    byte_done_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          state_d = ST_START;
          shift_d = data_i;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          baud_d      = '0;
          state_d     = ST_IDLE;
          byte_done_o = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // Line level for the bit currently being held.
  always_comb begin
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // State, counters and registered line output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/pic_uart_tx.sv
// Picture frame-dump transmitter: reads PIC_SIZE bytes from the picture RAM
// read port and sends each one as an 8N1 UART frame.
// Optional feature macro: PIC_UART_TX_CHECKSUM_EN appends a mod-256 sum byte.
// The sequencer holds ST_START while uart_byte_tx walks its own START/DATA/STOP
// bits; ST_STOP is a one-cycle tail that lines done up with the end of the
// (one-cycle-delayed) stop bit on the line.
module pic_uart_tx
  import pic_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned PIC_SIZE  = PIC_SIZE_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, BAUD_RATE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIC_SIZE - 1);

  pic_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ser_load;
  logic [7:0]        ser_data;
  logic              ser_ready;
  logic              ser_byte_done;
`ifdef PIC_UART_TX_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              sum_phase_q, sum_phase_d;
`endif

  assign rd_addr = addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

  uart_byte_tx #(
    .BAUD_CNT_MAX(BAUD_CNT_MAX)
  ) u_ser (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .load_i     (ser_load),
    .data_i     (ser_data),
    .ready_o    (ser_ready),
    .byte_done_o(ser_byte_done),
    .tx_o       (tx)
  );

  // Dump sequencing: accept, fetch, load serialiser, advance or finish.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    done_d   = 1'b0;
    ser_load = 1'b0;
`ifdef PIC_UART_TX_CHECKSUM_EN
    sum_d       = sum_q;
    sum_phase_d = sum_phase_q;
    ser_data    = sum_phase_q ? sum_q : rd_data;
`else
    ser_data    = rd_data;
`endif
    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        // A start coinciding with the done pulse is dropped, not queued.
        if (start && !done_q) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
`ifdef PIC_UART_TX_CHECKSUM_EN
          sum_d       = '0;
          sum_phase_d = 1'b0;
`endif
        end
      end
      ST_FETCH: begin
        addr_d  = cnt_q;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (ser_ready) begin
          ser_load = 1'b1;
          state_d  = ST_START;
`ifdef PIC_UART_TX_CHECKSUM_EN
          if (!sum_phase_q) begin
            sum_d = sum_q + rd_data;
          end
`endif
        end
      end
      ST_START: begin
        if (ser_byte_done) begin
`ifdef PIC_UART_TX_CHECKSUM_EN
          if (sum_phase_q) begin
            state_d = ST_STOP;
          end else if (cnt_q != LAST_ADDR) begin
            cnt_d   = cnt_q + 1'b1;
            addr_d  = cnt_q + 1'b1;
            state_d = ST_FETCH;
          end else begin
            // Sum byte needs no RAM access; rd_addr stays on the last pixel.
            sum_phase_d = 1'b1;
            state_d     = ST_LOAD;
          end
`else
          if (cnt_q != LAST_ADDR) begin
            cnt_d   = cnt_q + 1'b1;
            addr_d  = cnt_q + 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_STOP;
          end
`endif
        end
      end
      ST_STOP: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        addr_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer registers and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PIC_UART_TX_CHECKSUM_EN
      sum_q       <= '0;
      sum_phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PIC_UART_TX_CHECKSUM_EN
      sum_q       <= sum_d;
      sum_phase_q <= sum_phase_d;
`endif
    end
  end

endmodule

// File: doc/pic_uart_tx.md
# pic_uart_tx

Frame-dump transmitter: on a start pulse it reads a stored picture out of the dual-port picture RAM byte by byte and serialises each byte onto a UART TX line (8N1, LSB first). It is the return path of the UART picture-upload link, so the host can read back what the display RAM holds. It sits on the RAM's spare read port in the `sys_clk` domain.

## Interface
- `CLK_FREQ`, 50_000_000, `sys_clk` frequency in Hz
- `BAUD_RATE`, 9600, serial bit rate
- `PIC_SIZE`, 9604, bytes per dump (98x98 RGB332 picture)
- `ADDR_W`, 14, RAM address width; `PIC_SIZE` ≤ 2^`ADDR_W`
- `sys_clk`  in  1  single clock for all logic
- `sys_rst`  in  1  reset: **synchronous, active-high**
- `start`  in  1  one-cycle request to begin a dump; ignored while `busy`
- `rd_addr`  out  ADDR_W  RAM read address
- `rd_data`  in  8  RAM read data, valid one cycle after `rd_addr`
- `tx`  out  1  UART serial output, idle high
- `busy`  out  1  high from the cycle after `start` is accepted until the dump completes
- `done`  out  1  one-cycle pulse when the last bit of the dump has been sent

## Operation
- `BAUD_CNT_MAX = CLK_FREQ/BAUD_RATE` (integer division); every bit is held exactly `BAUD_CNT_MAX` cycles.
- States: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE: `tx`=1, `busy`=0, `rd_addr`=0. `start`=1 → FETCH, byte counter=0.
- FETCH: `rd_addr` = byte counter; one wait cycle → LOAD.
- LOAD: capture `rd_data` into shift register → START.
- START: `tx`=0 for one bit → DATA.
- DATA: 8 bits, LSB first; bit index 0..7 → STOP.
- STOP: `tx`=1 for one bit. If byte counter = `PIC_SIZE`-1: → IDLE with `done` pulse. Otherwise increment counter → FETCH.
- The byte counter is `ADDR_W` bits wide and never wraps past `PIC_SIZE`-1 within a dump.
- `start` while `busy` is ignored and never queued. `start` in the same cycle as `done` is also ignored, and is accepted only from IDLE.
- Reset at any time: on the next edge all state returns to IDLE, `tx`=1, `busy`=0, `done`=0, `rd_addr`=0, and the counters are cleared. The partial frame is abandoned.
- All outputs are registered.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `rd_addr`=0.
- `start` sampled high at edge k → `busy`=1 and FETCH after k; LOAD after k+1; `tx` falls after edge k+3.
- Byte period on the line is 10·`BAUD_CNT_MAX` cycles. There are 2 extra `tx`-high cycles (FETCH+LOAD) between consecutive stop and start bits.
- `done`=1 for the single cycle after the last stop bit's final cycle. `busy` falls in that same cycle.
- Total dump length is `PIC_SIZE`·(10·`BAUD_CNT_MAX`+2)+1 cycles from `start` to `done`. This excludes the checksum byte.

## Configuration
- `PIC_UART_TX_CHECKSUM_EN` defined: after the last pixel byte, one extra byte is sent using the same 8N1 framing. That byte is the mod-256 sum of all `PIC_SIZE` bytes sent. No FETCH/LOAD is performed for it and `rd_addr` holds `PIC_SIZE`-1. `done` follows its stop bit. The sum register clears on accept of `start` and on reset.
- Not defined: exactly `PIC_SIZE` bytes are sent and no sum logic exists.

## Structure
- Shared package `pic_pkg`: the state enum, the default `PIC_SIZE`/`ADDR_W` constants used across the picture path, and the constant function computing `BAUD_CNT_MAX`.
- One sub-module: `uart_byte_tx`, a single-byte 8N1 serialiser with `load`/`data`/`ready`, plus a baud counter. The top owns the FETCH/LOAD/address/checksum sequencing.

## Test plan
Use `CLK_FREQ`=1000, `BAUD_RATE`=100 (10 cycles per bit) and `PIC_SIZE`=4. RAM model holds 0xA5, 0x3C, 0xFF, 0x00.
- Reset then idle 50 cycles → `tx`=1, `busy`=0, `done`=0, `rd_addr`=0 throughout.
- `start` pulse at edge k → `tx` low after k+3. Line decodes to 0xA5, 0x3C, 0xFF, 0x00 with 2-cycle gaps. `done` pulses once, 4·102+1 cycles after k.
- `start` re-pulsed mid-dump and in the `done` cycle → no extra bytes, no restart.
- `sys_rst` asserted during the DATA bits of byte 2 → next edge `tx`=1, `busy`=0. A subsequent `start` sends the full 4 bytes from address 0.
- Checksum macro defined → fifth byte 0xE0 (0xA5+0x3C+0xFF+0x00 mod 256). `done` follows its stop bit.
- Every bit width measured at exactly 10 cycles. Stop bit high and start bit low each time.
